freq_sweeper: RTL and testbench

Sweep engine between the configuration/input stage and the DDS phase accumulator. It takes the configured centre frequency, sweep range, sweep speed and sweep mode, and produces the instantaneous output frequency. The output steps once per millisecond in sawtooth-up, sawtooth-down or triangle fashion, clamped to the legal 1–999999 Hz band. With sweep disabled, the configured frequency passes through unchanged after one register stage.

---
 rtl/freq_sweep_pkg.sv | 29 ++
 rtl/freq_sweeper_if.sv | 25 ++
 rtl/freq_sweeper_tick.sv | 37 +++
 rtl/freq_sweeper.sv | 149 ++++++++++++++
 tb/tb_freq_sweeper.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/freq_sweep_pkg.sv
// Shared definitions for the frequency sweep engine: field widths,
// legal output band, sweep mode encodings and step FSM states.
package freq_sweep_pkg;

    localparam int FREQ_W  = 20;
    localparam int RANGE_W = 17;
    localparam int SPEED_W = 13;

    // Bound and step arithmetic is one bit wider than the frequency field
    // so centre + range and freq + speed never overflow.
    localparam int CALC_W = 21;

    localparam logic [CALC_W-1:0] FREQ_MIN = 21'd1;
    localparam logic [CALC_W-1:0] FREQ_MAX = 21'd999999;

    typedef enum logic [1:0] {
        SWEEP_OFF  = 2'b00,
        SWEEP_UP   = 2'b01,
        SWEEP_DOWN = 2'b10,
        SWEEP_TRI  = 2'b11
    } sweep_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/freq_sweeper_if.sv
// Configuration inputs and instantaneous-frequency outputs of the sweep
// engine. The master side supplies the configuration; the slave side is
// the sweeper itself.
interface freq_sweeper_if;
    import freq_sweep_pkg::*;

    logic [FREQ_W-1:0]  freq_center;
    logic [RANGE_W-1:0] sweep_range;
    logic [SPEED_W-1:0] sweep_speed;
    logic [1:0]         sweep_mode;
    logic [FREQ_W-1:0]  freq_inst;
    logic               sweep_active;
    logic               sweep_wrap;

    modport master (
        output freq_center, sweep_range, sweep_speed, sweep_mode,
        input  freq_inst, sweep_active, sweep_wrap
    );

    modport slave (
        input  freq_center, sweep_range, sweep_speed, sweep_mode,
        output freq_inst, sweep_active, sweep_wrap
    );

endinterface

// File: rtl/freq_sweeper_tick.sv
// Free-running millisecond divider. tick is high for one cycle every
// CLK_HZ/1000 cycles; clr restarts the count from zero.
module ms_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int DIV   = CLK_HZ / 1000;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_W'(DIV - 1));

    // Count up to DIV-1 then roll over; a clear forces the count back to 0.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/freq_sweeper.sv
// Sweep engine: derives the clamped sweep band from the configuration and
// steps the instantaneous frequency once per millisecond in sawtooth-up,
// sawtooth-down or triangle fashion. Mode 00 passes the centre through.
module freq_sweeper
    import freq_sweep_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic           clk,
    input  logic           rst,
    freq_sweeper_if.slave  bus
);

    sweep_state_e       state_q, state_d;
    sweep_state_e       start_state;
    sweep_mode_e        mode_q, in_mode, sel_mode;
    logic [CALC_W-1:0]  freq_q, freq_d, start_freq;
    logic               wrap_q, wrap_d;
    logic               first_q;
    logic               load;
    logic               tick;

    logic [CALC_W-1:0]  center_w, range_w, speed_w;
    logic [CALC_W-1:0]  sum_hi, f_lo, f_hi, up_sum, lo_plus;
    logic               out_band;

    assign in_mode  = sweep_mode_e'(bus.sweep_mode);
    assign center_w = CALC_W'(bus.freq_center);
    assign range_w  = CALC_W'(bus.sweep_range);
    assign speed_w  = CALC_W'(bus.sweep_speed);

    // A new start point is taken on the first cycle out of reset and
    // whenever the requested mode differs from the one last seen.
    assign load = first_q || (in_mode != mode_q);

    ms_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .tick (tick)
    );

    // Sweep band clamped to the legal output range, plus the step sums.
    always_comb begin
        sum_hi   = center_w + range_w;
        f_hi     = (sum_hi > FREQ_MAX) ? FREQ_MAX : sum_hi;
        f_lo     = (range_w >= center_w) ? FREQ_MIN : (center_w - range_w);
        up_sum   = freq_q + speed_w;
        lo_plus  = f_lo + speed_w;
        out_band = (freq_q < f_lo) || (freq_q > f_hi);
    end

    // Start point for the mode being entered (or re-entered after a live
    // parameter change pushed the frequency out of the band).
    always_comb begin
        sel_mode    = load ? in_mode : mode_q;
        start_state = IDLE;
        start_freq  = center_w;
        case (sel_mode)
            SWEEP_UP:   begin start_state = UP;   start_freq = f_lo; end
            SWEEP_DOWN: begin start_state = DOWN; start_freq = f_hi; end
            SWEEP_TRI:  begin start_state = UP;   start_freq = f_lo; end
            default:    begin start_state = IDLE; start_freq = center_w; end
        endcase
    end

    // Step FSM: mode change beats tick; on a tick either reload or step.
    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        wrap_d  = 1'b0;
        if (load) begin
            state_d = start_state;
            freq_d  = start_freq;
        end else if (state_q == IDLE) begin
            freq_d = center_w;
        end else if (tick) begin
            if (out_band) begin
                state_d = start_state;
                freq_d  = start_freq;
            end else begin
                case (mode_q)
                    SWEEP_UP: begin
                        if (up_sum > f_hi) begin
                            freq_d = f_lo;
                            wrap_d = 1'b1;
                        end else begin
                            freq_d = up_sum;
                        end
                    end
                    SWEEP_DOWN: begin
                        if (freq_q < lo_plus) begin
                            freq_d = f_hi;
                            wrap_d = 1'b1;
                        end else begin
                            freq_d = freq_q - speed_w;
                        end
                    end
                    SWEEP_TRI: begin
                        if (state_q == UP) begin
                            if (up_sum >= f_hi) begin
                                freq_d  = f_hi;
                                state_d = DOWN;
                                wrap_d  = 1'b1;
                            end else begin
                                freq_d = up_sum;
                            end
                        end else begin
                            if (freq_q <= lo_plus) begin
                                freq_d  = f_lo;
                                state_d = UP;
                                wrap_d  = 1'b1;
                            end else begin
                                freq_d = freq_q - speed_w;
                            end
                        end
                    end
                    default: begin
                        freq_d = freq_q;
                    end
                endcase
            end
        end
    end

    // State, output and mode-history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            freq_q  <= '0;
            wrap_q  <= 1'b0;
            mode_q  <= SWEEP_OFF;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            wrap_q  <= wrap_d;
            mode_q  <= in_mode;
            first_q <= 1'b0;
        end
    end

    assign bus.freq_inst    = freq_q[FREQ_W-1:0];
    assign bus.sweep_wrap   = wrap_q;
    assign bus.sweep_active = (mode_q != SWEEP_OFF);

endmodule

// File: tb/tb_freq_sweeper.sv
// Directed bench for freq_sweeper at CLK_HZ=10_000 (one tick every 10
// cycles). Expected values are worked out by hand from the sweep rules.
module tb_freq_sweeper;

    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;

    freq_sweeper_if sweepIf ();

    freq_sweeper #(
        .CLK_HZ (10_000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sweepIf)
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive the full configuration onto the interface.
    task automatic applyStimulus(input logic [1:0] mode, input int center,
                                 input int range, input int speed);
        sweepIf.sweep_mode  = mode;
        sweepIf.freq_center = 20'(center);
        sweepIf.sweep_range = 17'(range);
        sweepIf.sweep_speed = 13'(speed);
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Directed scenario sequence.
    initial begin
        checkCount = 0;
        errorCount = 0;
        rst = 1'b1;
        applyStimulus(2'b00, 100000, 0, 0);
        waitCycles(3);
        checkOutput("reset freq", 32'(sweepIf.freq_inst), 0);
        checkOutput("reset active", 32'(sweepIf.sweep_active), 0);
        checkOutput("reset wrap", 32'(sweepIf.sweep_wrap), 0);

        // Mode 00 pass-through with one cycle of latency.
        rst = 1'b0;
        waitCycles(1);
        checkOutput("idle first", 32'(sweepIf.freq_inst), 100000);
        applyStimulus(2'b00, 123456, 0, 0);
        waitCycles(1);
        checkOutput("idle follow", 32'(sweepIf.freq_inst), 123456);
        checkOutput("idle active", 32'(sweepIf.sweep_active), 0);

        // Sawtooth up between 80000 and 120000 in 1000 Hz steps.
        applyStimulus(2'b01, 100000, 20000, 1000);
        waitCycles(1);
        checkOutput("up start", 32'(sweepIf.freq_inst), 80000);
        checkOutput("up active", 32'(sweepIf.sweep_active), 1);
        waitCycles(9);
        checkOutput("up pre-tick", 32'(sweepIf.freq_inst), 80000);
        waitCycles(1);
        checkOutput("up step1", 32'(sweepIf.freq_inst), 81000);
        checkOutput("up step1 wrap", 32'(sweepIf.sweep_wrap), 0);
        for (int k = 2; k <= 41; k++) begin
            waitCycles(10);
            checkOutput("up seq", 32'(sweepIf.freq_inst), (k <= 40) ? 80000 + 1000 * k : 80000);
            checkOutput("up seq wrap", 32'(sweepIf.sweep_wrap), (k == 41) ? 1 : 0);
        end
        waitCycles(1);
        checkOutput("up wrap one cycle", 32'(sweepIf.sweep_wrap), 0);

        // Mode change to triangle on a tick cycle: start point wins, no step.
        waitCycles(8);
        applyStimulus(2'b11, 100000, 20000, 1000);
        waitCycles(1);
        checkOutput("collide start", 32'(sweepIf.freq_inst), 80000);
        checkOutput("collide wrap", 32'(sweepIf.sweep_wrap), 0);
        waitCycles(10);
        checkOutput("collide step", 32'(sweepIf.freq_inst), 81000);

        // Reset mid-sweep, reconfigured for the triangle scenario meanwhile.
        waitCycles(5);
        rst = 1'b1;
        applyStimulus(2'b11, 10000, 20000, 4000);
        waitCycles(1);
        checkOutput("midrst freq", 32'(sweepIf.freq_inst), 0);
        checkOutput("midrst wrap", 32'(sweepIf.sweep_wrap), 0);
        checkOutput("midrst active", 32'(sweepIf.sweep_active), 0);

        // Triangle with f_lo clamped to 1 and f_hi = 30000.
        rst = 1'b0;
        waitCycles(1);
        checkOutput("tri start", 32'(sweepIf.freq_inst), 1);
        for (int k = 1; k <= 17; k++) begin
            int expF;
            if (k <= 7)       expF = 1 + 4000 * k;
            else if (k == 8)  expF = 30000;
            else if (k <= 15) expF = 30000 - 4000 * (k - 8);
            else if (k == 16) expF = 1;
            else              expF = 4001;
            waitCycles(10);
            checkOutput("tri seq", 32'(sweepIf.freq_inst), 32'(expF));
            checkOutput("tri seq wrap", 32'(sweepIf.sweep_wrap), (k == 8 || k == 16) ? 1 : 0);
        end

        // Sawtooth down with f_hi clamped to 999999, f_lo = 940000.
        applyStimulus(2'b10, 990000, 50000, 3000);
        waitCycles(1);
        checkOutput("down start", 32'(sweepIf.freq_inst), 999999);
        for (int k = 1; k <= 21; k++) begin
            int expF;
            if (k <= 19)      expF = 999999 - 3000 * k;
            else if (k == 20) expF = 999999;
            else              expF = 996999;
            waitCycles(10);
            checkOutput("down seq", 32'(sweepIf.freq_inst), 32'(expF));
            checkOutput("down seq wrap", 32'(sweepIf.sweep_wrap), (k == 20) ? 1 : 0);
        end

        // Zero speed holds at f_lo with no wrap.
        applyStimulus(2'b01, 100000, 20000, 0);
        waitCycles(1);
        checkOutput("hold start", 32'(sweepIf.freq_inst), 80000);
        for (int k = 1; k <= 3; k++) begin
            waitCycles(10);
            checkOutput("hold freq", 32'(sweepIf.freq_inst), 80000);
            checkOutput("hold wrap", 32'(sweepIf.sweep_wrap), 0);
        end

        // Climb to 110000, then shrink the range so it lies above f_hi.
        applyStimulus(2'b01, 100000, 20000, 1000);
        for (int m = 1; m <= 30; m++) begin
            waitCycles(10);
            checkOutput("climb", 32'(sweepIf.freq_inst), 32'(80000 + 1000 * m));
        end
        applyStimulus(2'b01, 100000, 5000, 1000);
        waitCycles(1);
        checkOutput("no reclamp", 32'(sweepIf.freq_inst), 110000);
        waitCycles(9);
        checkOutput("reload freq", 32'(sweepIf.freq_inst), 95000);
        checkOutput("reload wrap", 32'(sweepIf.sweep_wrap), 0);
        waitCycles(10);
        checkOutput("after reload", 32'(sweepIf.freq_inst), 96000);

        // Back to pass-through.
        applyStimulus(2'b00, 55555, 0, 0);
        waitCycles(1);
        checkOutput("idle again", 32'(sweepIf.freq_inst), 55555);
        checkOutput("idle again active", 32'(sweepIf.sweep_active), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
